// File: rtl/fpu_div_sqrt.sv
// fpu_div_sqrt: iterative parametrised IEEE-754 divide / square-root unit with RISC-V fflags
// Ports: clk, reset (async, active-high); valid_in/ready_in request handshake with op, rm, frm, a, b;
//        valid_out/ready_out result handshake with result and fflags {NV,DZ,OF,UF,NX}.
module fpu_div_sqrt #(
    parameter int EXP_WIDTH = 8,
    parameter int MAN_WIDTH = 23,
    localparam int W = 1 + EXP_WIDTH + MAN_WIDTH
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         valid_in,
    output logic         ready_in,
    input  logic [4:0]   op,
    input  logic [2:0]   rm,
    input  logic [2:0]   frm,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic         valid_out,
    input  logic         ready_out,
    output logic [W-1:0] result,
    output logic [4:0]   fflags
);
    localparam int XW = EXP_WIDTH + 2;
    localparam int QW = MAN_WIDTH + 3;
    localparam int RW = MAN_WIDTH + 6;
    localparam int CW = $clog2(QW);
    localparam logic [4:0] OP_DIV = 5'd10;
    localparam logic [4:0] OP_SQRT = 5'd11;
    localparam logic [2:0] RNE = 3'b000, RDN = 3'b010, RUP = 3'b011, RMM = 3'b100;
    localparam logic [4:0] F_NV = 5'b10000, F_DZ = 5'b01000;
    localparam logic signed [XW-1:0] BIAS = XW'(2 ** (EXP_WIDTH - 1) - 1);
    localparam logic signed [XW-1:0] EMAX = XW'(2 ** EXP_WIDTH - 1);
    localparam logic signed [XW-1:0] EONE = 1;
    localparam logic [EXP_WIDTH-1:0] EONES = '1;
    localparam logic [W-1:0] QNAN = {1'b0, EONES, 1'b1, {(MAN_WIDTH - 1){1'b0}}};
    localparam logic [CW-1:0] LAST = CW'(QW - 1);

    typedef enum logic [2:0] {IDLE, PRENORM, SETUP, ITER, POSTNORM, ROUND, DONE} state_t;
    state_t state_q, state_d;

    logic                    sa, sb;
    logic [EXP_WIDTH-1:0]    ea_f, eb_f;
    logic [MAN_WIDTH-1:0]    fa, fb;
    logic                    a_ez, b_ez, a_zero, b_zero, a_inf, b_inf, a_nan, b_nan, a_snan, b_snan;
    logic                    is_sqrt, acc, spc;
    logic [2:0]              rm_e;
    logic [W-1:0]            spc_res;
    logic [4:0]              spc_flg;

    logic                    sign_q, sqrt_q, spc_q, stk_q;
    logic [2:0]              rm_q;
    logic signed [XW-1:0]    e_q, eb_q;
    logic [MAN_WIDTH+1:0]    ma_q;
    logic [MAN_WIDTH:0]      mb_q;
    logic [RW-1:0]           rem_q;
    logic [2*QW-1:0]         rad_q;
    logic [QW-1:0]           q_q;
    logic [CW-1:0]           cnt_q;
    logic [W-1:0]            res_q;
    logic [4:0]              flg_q;

    assign {sa, ea_f, fa} = a;
    assign {sb, eb_f, fb} = b;
    assign a_ez    = ea_f == '0;
    assign b_ez    = eb_f == '0;
    assign a_zero  = a_ez & (fa == '0);
    assign b_zero  = b_ez & (fb == '0);
    assign a_inf   = (&ea_f) & (fa == '0);
    assign b_inf   = (&eb_f) & (fb == '0);
    assign a_nan   = (&ea_f) & (|fa);
    assign b_nan   = (&eb_f) & (|fb);
    assign a_snan  = a_nan & !fa[MAN_WIDTH-1];
    assign b_snan  = b_nan & !fb[MAN_WIDTH-1];
    assign is_sqrt = op == OP_SQRT;
    assign rm_e    = (rm == 3'b111) ? frm : rm;
    assign acc     = valid_in & (state_q == IDLE) & ((op == OP_DIV) | is_sqrt);

    // Operands whose result is fixed by IEEE rules bypass the datapath entirely.
    always_comb begin
        spc     = 1'b1;
        spc_res = QNAN;
        spc_flg = '0;
        if (rm_e > RMM) spc_flg = F_NV;
        else if (is_sqrt) begin
            if (a_nan) spc_flg = a_snan ? F_NV : 5'b0;
            else if (a_zero) spc_res = {sa, {(W - 1){1'b0}}};
            else if (sa) spc_flg = F_NV;
            else if (a_inf) spc_res = {1'b0, EONES, {MAN_WIDTH{1'b0}}};
            else spc = 1'b0;
        end else begin
            if (a_nan | b_nan) spc_flg = (a_snan | b_snan) ? F_NV : 5'b0;
            else if ((a_zero & b_zero) | (a_inf & b_inf)) spc_flg = F_NV;
            else if (a_inf) spc_res = {sa ^ sb, EONES, {MAN_WIDTH{1'b0}}};
            else if (b_zero) begin
                spc_res = {sa ^ sb, EONES, {MAN_WIDTH{1'b0}}};
                spc_flg = F_DZ;
            end else if (b_inf | a_zero) spc_res = {sa ^ sb, {(W - 1){1'b0}}};
            else spc = 1'b0;
        end
    end

    // Prenormalisation finishes when the shift being applied sets the hidden bit(s).
    logic pn_done;
    assign pn_done = !ma_q[MAN_WIDTH] ? ma_q[MAN_WIDTH-1] & (sqrt_q | mb_q[MAN_WIDTH]) : mb_q[MAN_WIDTH-1];

    // Setup: keep the quotient in [1,2) for divide and make the exponent even for sqrt.
    logic                 lt;
    logic signed [XW-1:0] ue, su_e;
    logic [MAN_WIDTH+1:0] su_ma;
    assign lt    = ma_q < {1'b0, mb_q};
    assign ue    = e_q - BIAS;
    assign su_ma = (sqrt_q ? ue[0] : lt) ? ma_q << 1 : ma_q;
    assign su_e  = sqrt_q ? (ue >>> 1) + BIAS : lt ? e_q - eb_q + BIAS - EONE : e_q - eb_q + BIAS;

    // One restoring step: divide compares against the divisor, sqrt against {root, 01}.
    logic [RW-1:0] rx, trial, it_rem;
    logic          div_ge, sq_ge, it_ge;
    assign rx     = {rem_q[RW-3:0], rad_q[2*QW-1 -: 2]};
    assign trial  = RW'({q_q, 2'b01});
    assign div_ge = rem_q >= RW'(mb_q);
    assign sq_ge  = rx >= trial;
    assign it_ge  = sqrt_q ? sq_ge : div_ge;
    assign it_rem = sqrt_q ? (sq_ge ? rx - trial : rx) : ((div_ge ? rem_q - RW'(mb_q) : rem_q) << 1);

    // Rounding of {integer, fraction, guard, round} plus sticky.
    logic [MAN_WIDTH:0]   man, mr;
    logic [MAN_WIDTH+1:0] sum;
    logic                 g, r, nx, inc, of, tiny, ovf_inf;
    logic signed [XW-1:0] er;
    logic [W-1:0]         rnd_res;
    assign man  = q_q[QW-1:2];
    assign g    = q_q[1];
    assign r    = q_q[0];
    assign nx   = g | r | stk_q;
    assign inc  = (rm_q == RNE) ? g & (r | stk_q | man[0]) :
                  (rm_q == RDN) ? sign_q & nx :
                  (rm_q == RUP) ? !sign_q & nx :
                  (rm_q == RMM) ? g : 1'b0;
    assign sum  = {1'b0, man} + {{(MAN_WIDTH + 1){1'b0}}, inc};
    assign mr   = sum[MAN_WIDTH+1] ? sum[MAN_WIDTH+1:1] : sum[MAN_WIDTH:0];
    assign er   = e_q + {{(XW - 1){1'b0}}, sum[MAN_WIDTH+1]};
    assign tiny = !mr[MAN_WIDTH];
    assign of   = !tiny & (er >= EMAX);
    assign ovf_inf = (rm_q == RNE) | (rm_q == RMM) | ((rm_q == RUP) & !sign_q) | ((rm_q == RDN) & sign_q);
    assign rnd_res = !of ? {sign_q, tiny ? {EXP_WIDTH{1'b0}} : er[EXP_WIDTH-1:0], mr[MAN_WIDTH-1:0]} :
                     ovf_inf ? {sign_q, EONES, {MAN_WIDTH{1'b0}}} :
                     {sign_q, EONES - 1'b1, {MAN_WIDTH{1'b1}}};

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:     if (acc) state_d = spc ? ROUND : (a_ez | (!is_sqrt & b_ez)) ? PRENORM : SETUP;
            PRENORM:  if (pn_done) state_d = SETUP;
            SETUP:    state_d = ITER;
            ITER:     if (cnt_q == LAST) state_d = (e_q < EONE) ? POSTNORM : ROUND;
            POSTNORM: if ((e_q == '0) | (q_q[QW-1:1] == '0)) state_d = ROUND;
            ROUND:    state_d = DONE;
            DONE:     if (ready_out) state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= IDLE;
        else state_q <= state_d;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sign_q <= 1'b0;
            sqrt_q <= 1'b0;
            spc_q  <= 1'b0;
            stk_q  <= 1'b0;
            rm_q   <= '0;
            e_q    <= '0;
            eb_q   <= '0;
            ma_q   <= '0;
            mb_q   <= '0;
            rem_q  <= '0;
            rad_q  <= '0;
            q_q    <= '0;
            cnt_q  <= '0;
            res_q  <= '0;
            flg_q  <= '0;
        end else begin
            case (state_q)
                IDLE: if (acc) begin
                    sign_q <= !is_sqrt & (sa ^ sb);
                    sqrt_q <= is_sqrt;
                    spc_q  <= spc;
                    rm_q   <= rm_e;
                    e_q    <= {2'b00, ea_f} | XW'(a_ez);
                    eb_q   <= {2'b00, eb_f} | XW'(b_ez);
                    ma_q   <= {1'b0, !a_ez, fa};
                    mb_q   <= {!b_ez, fb};
                    res_q  <= spc_res;
                    flg_q  <= spc_flg;
                end
                PRENORM: if (!ma_q[MAN_WIDTH]) begin
                    ma_q <= ma_q << 1;
                    e_q  <= e_q - EONE;
                end else begin
                    mb_q <= mb_q << 1;
                    eb_q <= eb_q - EONE;
                end
                SETUP: begin
                    e_q   <= su_e;
                    rem_q <= sqrt_q ? '0 : RW'(su_ma);
                    rad_q <= {su_ma, {(MAN_WIDTH + 4){1'b0}}};
                    q_q   <= '0;
                    cnt_q <= '0;
                end
                ITER: begin
                    q_q   <= {q_q[QW-2:0], it_ge};
                    rem_q <= it_rem;
                    rad_q <= rad_q << 2;
                    stk_q <= |it_rem;
                    cnt_q <= cnt_q + 1'b1;
                end
                POSTNORM: begin
                    q_q   <= q_q >> 1;
                    stk_q <= stk_q | q_q[0];
                    e_q   <= e_q + EONE;
                end
                ROUND: if (!spc_q) begin
                    res_q <= rnd_res;
                    flg_q <= {2'b00, of, tiny & nx, nx | of};
                end
                default: ;
            endcase
        end
    end

    assign ready_in  = state_q == IDLE;
    assign valid_out = state_q == DONE;
    assign result    = res_q;
    assign fflags    = flg_q;
endmodule

// File: tb/tb_fpu_div_sqrt.sv
// tb_fpu_div_sqrt: directed single-precision vectors for fpu_div_sqrt
module tb_fpu_div_sqrt;
    localparam logic [4:0] DIV = 5'd10, SQRT = 5'd11;
    localparam logic [2:0] RNE = 3'b000, RTZ = 3'b001, RUP = 3'b011, DYN = 3'b111;
    localparam logic [4:0] NV = 5'h10, DZ = 5'h08, OF = 5'h04, UF = 5'h02, NX = 5'h01;

    logic        clk, reset, valid_in, ready_in, valid_out, ready_out;
    logic [4:0]  op, fflags;
    logic [2:0]  rm, frm;
    logic [31:0] a, b, result;
    int          n_vec, n_err;

    fpu_div_sqrt dut (
        .clk(clk), .reset(reset), .valid_in(valid_in), .ready_in(ready_in), .op(op), .rm(rm), .frm(frm),
        .a(a), .b(b), .valid_out(valid_out), .ready_out(ready_out), .result(result), .fflags(fflags)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, want %h", tag, got, exp);
        end
    endtask

    task automatic run(input string tag, input logic [4:0] o, input logic [2:0] r, input logic [2:0] f,
                       input logic [31:0] x, input logic [31:0] y, input logic [31:0] er,
                       input logic [4:0] ef, input int el, input int hold, input int poke);
        int lat;
        @(negedge clk);
        check({tag, ".rdy"}, 32'(ready_in), 32'd1);
        op = o; rm = r; frm = f; a = x; b = y; valid_in = 1'b1;
        @(posedge clk);
        #1 valid_in = 1'b0;
        lat = 1;
        while (!valid_out && lat < 300) begin
            if (lat == poke) begin
                valid_in = 1'b1; op = SQRT; a = 32'h40800000;
            end
            @(posedge clk);
            #1 valid_in = 1'b0;
            lat++;
        end
        check({tag, ".vld"}, 32'(valid_out), 32'd1);
        check({tag, ".res"}, result, er);
        check({tag, ".flg"}, 32'(fflags), 32'(ef));
        if (el > 0) check({tag, ".lat"}, 32'(lat), 32'(el));
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            #1;
            check({tag, ".hold_res"}, result, er);
            check({tag, ".hold_flg"}, 32'(fflags), 32'(ef));
            check({tag, ".hold_rdy"}, 32'(ready_in), 32'd0);
        end
        @(negedge clk) ready_out = 1'b1;
        @(posedge clk);
        #1 ready_out = 1'b0;
        check({tag, ".idle"}, 32'({ready_in, valid_out}), 32'b10);
    endtask

    initial begin
        n_vec = 0; n_err = 0;
        reset = 1'b1; valid_in = 1'b0; ready_out = 1'b0;
        op = '0; rm = '0; frm = '0; a = '0; b = '0;
        #23;
        check("rst.rdy", 32'(ready_in), 32'd1);
        check("rst.vld", 32'(valid_out), 32'd0);
        check("rst.res", result, 32'd0);
        check("rst.flg", 32'(fflags), 32'd0);
        @(negedge clk) reset = 1'b0;

        run("div6_2",   DIV,  RNE, RNE, 32'h40C00000, 32'h40000000, 32'h40400000, 5'h00, 29, 0, 0);
        run("div1_3",   DIV,  RNE, RNE, 32'h3F800000, 32'h40400000, 32'h3EAAAAAB, NX, 29, 0, 0);
        run("div1_3dz", DIV,  DYN, RTZ, 32'h3F800000, 32'h40400000, 32'h3EAAAAAA, NX, 29, 0, 0);
        run("div_badrm", DIV, 3'b101, RNE, 32'h3F800000, 32'h40400000, 32'h7FC00000, NV, 2, 0, 0);
        run("sqrt2",    SQRT, RNE, RNE, 32'h40000000, 32'h0, 32'h3FB504F3, NX, 29, 0, 0);
        run("sqrt4",    SQRT, RNE, RNE, 32'h40800000, 32'h0, 32'h40000000, 5'h00, 29, 0, 0);
        run("div_x0",   DIV,  RNE, RNE, 32'h3F800000, 32'h00000000, 32'h7F800000, DZ, 2, 0, 0);
        run("div_00",   DIV,  RNE, RNE, 32'h00000000, 32'h00000000, 32'h7FC00000, NV, 2, 0, 0);
        run("sqrt_neg", SQRT, RNE, RNE, 32'hBF800000, 32'h0, 32'h7FC00000, NV, 2, 0, 0);
        run("sqrt_nz",  SQRT, RNE, RNE, 32'h80000000, 32'h0, 32'h80000000, 5'h00, 2, 0, 0);
        run("div_min",  DIV,  RNE, RNE, 32'h00800000, 32'h40000000, 32'h00400000, 5'h00, 30, 0, 0);
        run("div_tiny", DIV,  RNE, RNE, 32'h00000001, 32'h40000000, 32'h00000000, UF | NX, 76, 0, 0);
        run("div_tinyu", DIV, RUP, RNE, 32'h00000001, 32'h40000000, 32'h00000001, UF | NX, 76, 0, 0);
        run("div_ovf",  DIV,  RNE, RNE, 32'h7F7FFFFF, 32'h3F000000, 32'h7F800000, OF | NX, 29, 0, 0);
        run("div_ovfz", DIV,  RTZ, RNE, 32'h7F7FFFFF, 32'h3F000000, 32'h7F7FFFFF, OF | NX, 29, 0, 0);
        run("hold",     DIV,  RNE, RNE, 32'h3F800000, 32'h40400000, 32'h3EAAAAAB, NX, 29, 10, 0);
        run("poke",     DIV,  RNE, RNE, 32'h40C00000, 32'h40000000, 32'h40400000, 5'h00, 29, 0, 10);

        @(negedge clk);
        op = 5'd3; a = 32'h40C00000; b = 32'h40000000; valid_in = 1'b1;
        @(posedge clk);
        #1 valid_in = 1'b0;
        check("badop.rdy", 32'(ready_in), 32'd1);

        @(negedge clk);
        op = DIV; rm = RNE; a = 32'h40C00000; b = 32'h40000000; valid_in = 1'b1;
        @(posedge clk);
        #1 valid_in = 1'b0;
        repeat (10) @(posedge clk);
        #2;
        check("iter.rdy", 32'(ready_in), 32'd0);
        reset = 1'b1;
        #1;
        check("mid_rst.vld", 32'(valid_out), 32'd0);
        check("mid_rst.rdy", 32'(ready_in), 32'd1);
        check("mid_rst.res", result, 32'd0);
        @(negedge clk) reset = 1'b0;
        run("after_rst", DIV, RNE, RNE, 32'h3F800000, 32'h40400000, 32'h3EAAAAAB, NX, 29, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/fpu_div_sqrt.md
Name: fpu_div_sqrt

Overview:
- Iterative, parametrised IEEE-754 divide / square-root unit for the FPU execute stage.
- Generalises the single-precision-only operation set to arbitrary EXP_WIDTH/MAN_WIDTH.
- Handles FPU_OP_DIV (10) and FPU_OP_SQRT (11) with all five rounding modes plus DYN resolution from fcsr.
- Supports full subnormal input/output and returns RISC-V fflags over a valid/ready handshake.

Parameters:
- EXP_WIDTH, 8, exponent field width; bias = 2^(EXP_WIDTH-1)-1.
- MAN_WIDTH, 23, stored mantissa field width; W = 1+EXP_WIDTH+MAN_WIDTH.

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- valid_in  input  1  operation request.
- ready_in  output  1  unit can accept a request (IDLE).
- op  input  5  FPU_OP_DIV or FPU_OP_SQRT; other codes are ignored (not accepted).
- rm  input  3  instruction rounding mode; 3'b111 = DYN.
- frm  input  3  fcsr rounding mode, used when rm = DYN.
- a  input  W  dividend / radicand.
- b  input  W  divisor; ignored for SQRT.
- valid_out  output  1  result valid.
- ready_out  input  1  consumer accepts result.
- result  output  W  rounded result.
- fflags  output  5  {NV,DZ,OF,UF,NX}.

Behaviour:
- Reset (async, any state, including mid-iteration): state = IDLE, ready_in = 1, valid_out = 0, result = 0, fflags = 0. Any in-flight operation is discarded.
- Accept: a request is accepted when valid_in & ready_in & op ∈ {DIV, SQRT}. Operands, op and the effective rm are registered. ready_in drops the next cycle and rises again only on return to IDLE.
- Effective rm: rm, or frm if rm = 3'b111. If the effective rm ∈ {101, 110, 111}, the result is the canonical NaN with NV; the unit goes straight to DONE.
- States:
  - IDLE.
  - PRENORM: while the hidden bit is 0 (subnormal), shift the mantissa left 1/cycle and decrement the exponent, max MAN_WIDTH cycles per operand. b is normalised after a (DIV only).
  - SETUP (1 cycle). DIV: if ma < mb, shift ma left and decrement the exponent. SQRT: if the unbiased exponent is odd, shift ma left.
  - ITER: restoring radix-2, one quotient/root bit per cycle, MAN_WIDTH+3 cycles (integer, fraction, guard, round). Sticky = remainder != 0.
  - POSTNORM: if the biased exponent is < 1, shift right 1/cycle, ORing shifted-out bits into sticky, until exponent = 1 or the mantissa is zero.
  - ROUND (1 cycle).
  - DONE: hold valid_out, result and fflags stable until ready_out; then go to IDLE.
- Special cases skip from IDLE directly to DONE (2-cycle latency accept→valid_out):
  - Any sNaN: NV.
  - Any NaN: canonical NaN (exp all-ones, MSB of mantissa set, sign 0).
  - 0/0, inf/inf, sqrt(x<0, x ≠ -0): canonical NaN, NV.
  - x/0 with finite x ≠ 0: signed inf, DZ.
  - inf/x: signed inf.
  - x/inf and 0/x: signed zero.
  - sqrt(±0) = ±0; sqrt(+inf) = +inf.
- Exponent arithmetic: signed EXP_WIDTH+2 bits. DIV: ea - eb + bias. SQRT: ((ea - bias) >> 1) + bias, arithmetic shift. Sign: DIV = sa^sb; SQRT = 0.
- Rounding:
  - RNE: tie to even.
  - RTZ: truncate.
  - RDN / RUP: directed by sign.
  - RMM: tie away from zero.
  - A mantissa carry-out increments the exponent.
- Flags:
  - NX = guard|round|sticky after POSTNORM.
  - OF when the rounded exponent ≥ all-ones. Result: inf for RNE/RMM and for RUP(+)/RDN(-); otherwise max finite. OF implies NX.
  - UF = tiny & NX, with tininess detected after rounding (RISC-V).
- Latency, normal operands: 1 (accept) + PRENORM shifts + 1 + (MAN_WIDTH+3) + POSTNORM shifts + 1 → valid_out. Single-precision normal worst case without subnormals: 29 cycles.
- valid_in while busy: ignored, no queueing. ready_out is irrelevant outside DONE.
- Back-to-back: the new request is accepted in the cycle after the DONE handshake (ready_in = 1 in IDLE).

Test Plan:
- DIV a=0x40C00000, b=0x40000000, rm=RNE -> result 0x40400000, fflags 0.
- DIV a=0x3F800000, b=0x40400000 -> RNE 0x3EAAAAAB NX. rm=DYN, frm=RTZ -> 0x3EAAAAAA NX. rm=3'b101 -> 0x7FC00000 NV.
- SQRT a=0x40000000, RNE -> 0x3FB504F3 NX. SQRT a=0x40800000 -> 0x40000000, fflags 0.
- Specials:
  - 0x3F800000/0x00000000 -> 0x7F800000 DZ.
  - 0/0 -> 0x7FC00000 NV.
  - SQRT 0xBF800000 -> 0x7FC00000 NV.
  - SQRT 0x80000000 -> 0x80000000, fflags 0.
  - All of the above with valid_out exactly 2 cycles after accept.
- Subnormal/overflow:
  - 0x00800000/0x40000000 -> 0x00400000, fflags 0.
  - 0x00000001/0x40000000, RNE -> 0x00000000 UF|NX; RUP -> 0x00000001 UF|NX.
  - 0x7F7FFFFF/0x3F000000: RNE -> 0x7F800000 OF|NX; RTZ -> 0x7F7FFFFF OF|NX.
- Handshake/reset:
  - Hold ready_out=0 for 10 cycles in DONE -> result/fflags stable, ready_in=0.
  - Pulse valid_in mid-ITER -> ignored.
  - Assert reset during ITER -> valid_out=0, ready_in=1 immediately; next request completes correctly.
